// File: rtl/fifo_stream_pkg.sv
// Shared constants and types for the FIFO-to-stream read adapter.
package fifo_stream_pkg;

    localparam int BUF_ENTRIES = 2;

    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying words out of the FIFO reader.
interface fifo_stream_reader_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_stream_buf.sv
// Two-entry register FIFO; entry 0 is always the head so the output is a plain register.
module fifo_stream_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output occ_t             occ
);

    logic [WIDTH-1:0] entry_reg [BUF_ENTRIES];
    occ_t             occ_reg;
    occ_t             occ_next;
    occ_t             wr_idx;

    // The write slot is computed after the pop shift, so push+pop keeps order.
    assign wr_idx   = occ_reg - occ_t'(pop);
    assign occ_next = occ_reg + occ_t'(push) - occ_t'(pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push && wr_idx == occ_t'(0)) begin
            entry_reg[0] <= push_data;
        end else if (pop) begin
            entry_reg[0] <= entry_reg[1];
        end
        if (push && wr_idx == occ_t'(1)) begin
            entry_reg[1] <= push_data;
        end
    end

    assign head_data = entry_reg[0];
    assign occ       = occ_reg;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO port into a valid/ready stream at one word per clock.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 fifo_rd,
    input  logic [WIDTH-1:0]     fifo_rdata,
    input  logic                 fifo_rvalid,
    input  logic                 fifo_not_empty,
    fifo_stream_reader_if.master m,
    output occ_t                 occupancy,
    output logic                 err_underrun
);

    logic       inflight_reg;
    logic       err_reg;
    logic       pop;
    logic       push;
    occ_t       occ;
    logic [2:0] committed;

    assign pop  = m.valid & m.ready;
    assign push = inflight_reg & fifo_rvalid;

    // Only issue a read if its data is guaranteed a free slot when it returns.
    assign committed = {1'b0, occ} + {2'b00, inflight_reg} - {2'b00, pop};
    assign fifo_rd   = fifo_not_empty & rstn & (committed < 3'(BUF_ENTRIES));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            inflight_reg <= fifo_rd;
            if (inflight_reg && !fifo_rvalid) begin
                err_reg <= 1'b1;
            end
        end
    end

    fifo_stream_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (fifo_rdata),
        .pop       (pop),
        .head_data (m.data),
        .occ       (occ)
    );

    assign m.valid      = (occ != '0);
    assign occupancy    = occ;
    assign err_underrun = err_reg;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader against a queue-based FIFO and stream model.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       fifo_rd;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_rvalid = 1'b0;
    logic       fifo_not_empty = 1'b0;
    logic       m_ready = 1'b0;
    logic [1:0] occupancy;
    logic       err_underrun;

    fifo_stream_reader_if #(.WIDTH(8)) m_if ();
    assign m_if.ready = m_ready;

    fifo_stream_reader #(.WIDTH(8)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .fifo_rd        (fifo_rd),
        .fifo_rdata     (fifo_rdata),
        .fifo_rvalid    (fifo_rvalid),
        .fifo_not_empty (fifo_not_empty),
        .m              (m_if.master),
        .occupancy      (occupancy),
        .err_underrun   (err_underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: words the FIFO holds, and words it has handed out that the stream still owes.
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    bit         inject_underrun = 0;

    int cyc = 0;
    int rd_cnt = 0, vld_cnt = 0, delivered = 0, loaded = 0;
    int rd_viol = 0, occ_viol = 0, hold_viol = 0;
    int rd_log[$];
    int v_log[$];
    bit         hold_prev = 0;
    logic [7:0] hold_data = 8'h00;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rstn) begin
        logic [7:0] w;
        if (!rstn) begin
            fifo_rvalid    <= 1'b0;
            fifo_not_empty <= 1'b0;
            fifo_q.delete();
            exp_q.delete();
        end else if (fifo_rd) begin
            if (inject_underrun) begin
                inject_underrun = 0;
                fifo_rvalid <= 1'b0;
            end else begin
                w = fifo_q.pop_front();
                fifo_rdata  <= w;
                fifo_rvalid <= 1'b1;
                exp_q.push_back(w);
            end
            fifo_not_empty <= (fifo_q.size() != 0);
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (rstn) begin
            if (fifo_rd) begin
                rd_cnt++;
                rd_log.push_back(cyc);
                if (!fifo_not_empty) rd_viol++;
            end
            if (m_if.valid) begin
                vld_cnt++;
                v_log.push_back(cyc);
            end
            if (occupancy > 2'd2) occ_viol++;
            if (hold_prev && m_if.valid && m_if.data !== hold_data) hold_viol++;
            hold_prev = m_if.valid && !m_ready;
            hold_data = m_if.data;
            if (m_if.valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(m_if.data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_data", 32'(m_if.data), 32'(e));
                end
                delivered++;
            end
        end
    end

    task automatic load(input logic [7:0] w);
        fifo_q.push_back(w);
        fifo_not_empty = 1'b1;
        loaded++;
    endtask

    task automatic clear_counts();
        rd_cnt = 0; vld_cnt = 0; delivered = 0; loaded = 0;
        rd_log.delete();
        v_log.delete();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        m_ready = 1'b1;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_in_time", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rstn = 1'b0;
        #1;
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_valid", 32'(m_if.valid), 32'd0);
        check("rst_rd", 32'(fifo_rd), 32'd0);
        check("rst_err", 32'(err_underrun), 32'd0);
        @(negedge clk) rstn = 1'b1;

        // Streaming at full rate.
        @(posedge clk); #1;
        clear_counts();
        m_ready = 1'b1;
        load(8'h11); load(8'h22); load(8'h33);
        drain(50);
        check("stream_rd_pulses", 32'(rd_log.size()), 32'd3);
        check("stream_valid_cycles", 32'(v_log.size()), 32'd3);
        if (rd_log.size() == 3 && v_log.size() == 3) begin
            check("stream_latency", 32'(v_log[0] - rd_log[0]), 32'd2);
            check("stream_rd_back2back", 32'(rd_log[2] - rd_log[0]), 32'd2);
            check("stream_valid_back2back", 32'(v_log[2] - v_log[0]), 32'd2);
        end
        check("stream_delivered", 32'(delivered), 32'd3);

        // Backpressure with five words, then a single pop at full occupancy.
        @(posedge clk); #1;
        clear_counts();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
        repeat (8) @(negedge clk);
        check("bp_rd_pulses", 32'(rd_cnt), 32'd2);
        check("bp_occ_full", 32'(occupancy), 32'd2);
        check("bp_head", 32'(m_if.data), 32'hA0);
        check("bp_no_rd_when_full", 32'(fifo_rd), 32'd0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        check("full_pop_rd", 32'(fifo_rd), 32'd1);
        check("full_pop_occ", 32'(occupancy), 32'd2);
        @(posedge clk); #1;
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("full_refill_occ", 32'(occupancy), 32'd2);
        check("full_refill_head", 32'(m_if.data), 32'hA1);
        drain(100);
        check("bp_delivered", 32'(delivered), 32'd5);
        check("hold_stable", 32'(hold_viol), 32'd0);

        // Underrun: first read of this word comes back with rvalid low.
        @(posedge clk); #1;
        clear_counts();
        inject_underrun = 1;
        load(8'h5C);
        @(negedge clk);
        check("ur_rd", 32'(fifo_rd), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("ur_err_set", 32'(err_underrun), 32'd1);
        check("ur_occ", 32'(occupancy), 32'd0);
        check("ur_valid", 32'(m_if.valid), 32'd0);
        drain(50);
        check("ur_delivered", 32'(delivered), 32'd1);
        check("ur_valid_cycles", 32'(vld_cnt), 32'd1);
        check("ur_err_sticky", 32'(err_underrun), 32'd1);

        // Empty FIFO for twenty cycles.
        @(posedge clk); #1;
        clear_counts();
        repeat (20) @(negedge clk);
        check("empty_rd", 32'(rd_cnt), 32'd0);
        check("empty_valid", 32'(vld_cnt), 32'd0);

        // Asynchronous reset while holding two words.
        @(posedge clk); #1;
        clear_counts();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'($urandom_range(0, 255)));
        repeat (8) @(negedge clk);
        check("pre_rst_occ", 32'(occupancy), 32'd2);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(m_if.valid), 32'd0);
        check("mid_rst_occ", 32'(occupancy), 32'd0);
        check("mid_rst_rd", 32'(fifo_rd), 32'd0);
        check("mid_rst_err", 32'(err_underrun), 32'd0);
        @(negedge clk) rstn = 1'b1;
        hold_prev = 0;

        // Random traffic and random backpressure.
        @(posedge clk); #1;
        clear_counts();
        hold_viol = 0;
        for (int c = 0; c < 400; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) load(8'($urandom_range(0, 255)));
            @(posedge clk); #1;
        end
        drain(300);
        check("rand_delivered", 32'(delivered), 32'(loaded));
        check("rand_hold_stable", 32'(hold_viol), 32'd0);
        check("rd_only_when_not_empty", 32'(rd_viol), 32'd0);
        check("occ_in_range", 32'(occ_viol), 32'd0);
        check("rand_no_underrun", 32'(err_underrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
